spi_txn_scheduler: RTL and testbench

//  Shares one 8-bit SPI byte engine among NREQ requesters, each owning one slave select line.

---
 rtl/spi_txn_scheduler.sv | 176 +++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler that lends one shared 8-bit SPI byte engine to NREQ requesters,
// framing each multi-byte transaction with chip-select setup and hold time.
module spi_txn_scheduler #(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*LEN_W-1:0] req_len_i,
  input  logic [7:0]            tx_data_i,
  output logic [NREQ-1:0]       req_grant_o,
  output logic                  tx_pop_o,
  output logic [7:0]            rx_data_o,
  output logic                  rx_valid_o,
  output logic [NREQ-1:0]       txn_done_o,
  output logic [NREQ-1:0]       spi_cs_o,
  output logic                  eng_start_o,
  output logic [7:0]            eng_tx_o,
  input  logic [7:0]            eng_rx_i,
  input  logic                  eng_done_i
);

  localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    WAIT,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        engTx_q, engTx_d;
  logic [7:0]        rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic [NREQ-1:0]   txnDone_q, txnDone_d;

  logic [PTR_W-1:0]  pickIdx;
  logic [LEN_W-1:0]  lenSel;

  // Walk downwards so the last hit, i.e. the first set bit at or after ptr, wins.
  function automatic logic [PTR_W-1:0] rrPick(input logic [NREQ-1:0] req,
                                              input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx;
    int               wrapped;
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      wrapped = (int'(ptr) + i) % NREQ;
      idx     = PTR_W'(wrapped);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign pickIdx = rrPick(req_valid_i, ptr_q);
  assign lenSel  = LEN_W'(req_len_i >> (int'(pickIdx) * LEN_W));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      remain_q  <= '0;
      cnt_q     <= '0;
      engTx_q   <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      txnDone_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      remain_q  <= remain_d;
      cnt_q     <= cnt_d;
      engTx_q   <= engTx_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
      txnDone_q <= txnDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    remain_d    = remain_q;
    cnt_d       = cnt_q;
    engTx_d     = engTx_q;
    rxData_d    = rxData_q;
    rxValid_d   = 1'b0;
    txnDone_d   = '0;
    eng_start_o = 1'b0;
    tx_pop_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          owner_d  = pickIdx;
          grant_d  = NREQ'(1) << pickIdx;
          remain_d = lenSel;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      XFER: begin
        eng_start_o = 1'b1;
        tx_pop_o    = 1'b1;
        engTx_d     = tx_data_i;
        state_d     = WAIT;
      end

      // Stray eng_done pulses only matter here; every other state ignores them.
      WAIT: begin
        if (eng_done_i) begin
          rxData_d  = eng_rx_i;
          rxValid_d = 1'b1;
          if (remain_q == '0) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            remain_d = remain_q - LEN_W'(1);
            state_d  = XFER;
          end
        end
      end

      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d     = '0;
          grant_d   = '0;
          txnDone_d = grant_q;
          ptr_d     = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // During XFER the engine sees tx_data directly; the register holds it afterwards.
  assign eng_tx_o    = (state_q == XFER) ? tx_data_i : engTx_q;
  assign req_grant_o = grant_q;
  assign spi_cs_o    = grant_q;
  assign rx_data_o   = rxData_q;
  assign rx_valid_o  = rxValid_q;
  assign txn_done_o  = txnDone_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler: directed transactions push expectations into
// queues and a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_spi_txn_scheduler;

  localparam int NREQ       = 4;
  localparam int LEN_W      = 4;
  localparam int CS_SETUP   = 2;
  localparam int CS_HOLD    = 2;
  localparam int ENG_DLY    = 8;
  localparam int WAIT_LIMIT = 2000;

  typedef struct {
    logic [NREQ-1:0] who;
    int              bytes;
    int              csLen;
  } doneExp_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       reqValid;
  logic [NREQ*LEN_W-1:0] reqLen;
  logic [7:0]            txData;
  logic [NREQ-1:0]       reqGrant, txnDone, spiCs;
  logic                  txPop, rxValid, engStart, engDone;
  logic [7:0]            rxData, engTx, engRx;
  logic                  engDoneModel, spurDone, engKill;
  logic [7:0]            engRxModel;

  logic [7:0]      txQ[$];
  logic [7:0]      engRespQ[$];
  logic [7:0]      expEngQ[$];
  logic [7:0]      expRxQ[$];
  logic [NREQ-1:0] expGrantQ[$];
  doneExp_t        expDoneQ[$];

  int checksTotal  = 0;
  int checksPassed = 0;
  int grantsSeen   = 0;
  int startsSeen   = 0;

  always #5 clock = ~clock;

  assign engDone = engDoneModel | spurDone;
  assign engRx   = spurDone ? 8'h99 : engRxModel;

  spi_txn_scheduler #(
    .NREQ(NREQ), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .req_valid_i(reqValid),
    .req_len_i(reqLen),
    .tx_data_i(txData),
    .req_grant_o(reqGrant),
    .tx_pop_o(txPop),
    .rx_data_o(rxData),
    .rx_valid_o(rxValid),
    .txn_done_o(txnDone),
    .spi_cs_o(spiCs),
    .eng_start_o(engStart),
    .eng_tx_o(engTx),
    .eng_rx_i(engRx),
    .eng_done_i(engDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Byte engine model: answers each eng_start ENG_DLY cycles later with the next response.
  initial begin : engine
    logic [7:0] resp;
    engDoneModel = 1'b0;
    engRxModel   = 8'h00;
    forever begin
      @(negedge clock);
      if (engStart && !reset) begin
        resp = (engRespQ.size() != 0) ? engRespQ.pop_front() : 8'hEE;
        repeat (ENG_DLY) @(posedge clock);
        #1;
        if (!engKill) begin
          engRxModel   = resp;
          engDoneModel = 1'b1;
          @(posedge clock);
          #1 engDoneModel = 1'b0;
        end
      end
    end
  end

  // Requester data source: presents the head of txQ and advances on tx_pop.
  initial begin : feeder
    logic popNow;
    txData = 8'h00;
    forever begin
      @(posedge clock);
      popNow = txPop;
      #1;
      if (popNow && txQ.size() != 0) void'(txQ.pop_front());
      txData = (txQ.size() != 0) ? txQ[0] : 8'h00;
    end
  end

  initial begin : monitor
    logic [NREQ-1:0] prevGrant, g;
    int              csRun, popCnt, rxCnt, sinceGrant, sinceDone;
    bit              firstStart;
    doneExp_t        d;
    prevGrant = '0; csRun = 0; popCnt = 0; rxCnt = 0;
    sinceGrant = 0; sinceDone = 0; firstStart = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevGrant = '0; csRun = 0; popCnt = 0; rxCnt = 0;
      end else begin
        sinceGrant++;
        sinceDone++;
        if (spiCs != '0) csRun++;
        if (reqGrant != '0 && prevGrant == '0) begin
          grantsSeen++;
          if (expGrantQ.size() == 0) checkOutput("unexpected grant", 32'(reqGrant), 32'd0);
          else begin
            g = expGrantQ.pop_front();
            checkOutput("req_grant", 32'(reqGrant), 32'(g));
            checkOutput("spi_cs at grant", 32'(spiCs), 32'(g));
          end
          sinceGrant = 0;
          firstStart = 1'b1;
        end
        if (engStart) begin
          startsSeen++;
          if (expEngQ.size() == 0) checkOutput("unexpected eng_start", 32'(engStart), 32'd0);
          else begin
            checkOutput("eng_tx", 32'(engTx), 32'(expEngQ.pop_front()));
            checkOutput("tx_pop with eng_start", 32'(txPop), 32'd1);
            if (firstStart) checkOutput("first eng_start latency", sinceGrant, CS_SETUP);
            else checkOutput("eng_start after eng_done", sinceDone, 1);
          end
          firstStart = 1'b0;
        end
        if (txPop) popCnt++;
        if (rxValid) begin
          rxCnt++;
          if (expRxQ.size() == 0) checkOutput("unexpected rx_valid", 32'(rxValid), 32'd0);
          else checkOutput("rx_data", 32'(rxData), 32'(expRxQ.pop_front()));
        end
        if (txnDone != '0) begin
          if (expDoneQ.size() == 0) checkOutput("unexpected txn_done", 32'(txnDone), 32'd0);
          else begin
            d = expDoneQ.pop_front();
            checkOutput("txn_done", 32'(txnDone), 32'(d.who));
            checkOutput("tx_pop count", popCnt, d.bytes);
            checkOutput("rx_valid count", rxCnt, d.bytes);
            checkOutput("spi_cs high cycles", csRun, d.csLen);
            checkOutput("spi_cs low at txn_done", 32'(spiCs), 32'd0);
          end
          csRun = 0; popCnt = 0; rxCnt = 0;
        end
        if (engDone) sinceDone = 0;
        prevGrant = reqGrant;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setLen(input int who, input int len);
    reqLen[who*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic expectTxn(input int who, input int len, input logic [31:0] txWord,
                           input logic [31:0] rxWord);
    doneExp_t d;
    expGrantQ.push_back(NREQ'(1) << who);
    for (int k = 0; k <= len; k++) begin
      txQ.push_back(txWord[8*k +: 8]);
      expEngQ.push_back(txWord[8*k +: 8]);
      engRespQ.push_back(rxWord[8*k +: 8]);
      expRxQ.push_back(rxWord[8*k +: 8]);
    end
    d.who   = NREQ'(1) << who;
    d.bytes = len + 1;
    d.csLen = CS_SETUP + (len + 1) * (1 + ENG_DLY) + CS_HOLD;
    expDoneQ.push_back(d);
  endtask

  task automatic waitGrants(input int target, input string what);
    int n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (grantsSeen < target && n < WAIT_LIMIT);
    if (grantsSeen < target) checkOutput({"timeout grant ", what}, grantsSeen, target);
  endtask

  task automatic waitStarts(input int target, input string what);
    int n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (startsSeen < target && n < WAIT_LIMIT);
    if (startsSeen < target) checkOutput({"timeout eng_start ", what}, startsSeen, target);
  endtask

  task automatic waitDrain(input string what);
    int n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (expDoneQ.size() != 0 && n < WAIT_LIMIT);
    if (expDoneQ.size() != 0) checkOutput({"timeout txn_done ", what}, expDoneQ.size(), 0);
    repeat (3) @(posedge clock);
  endtask

  // Raise the mask, drop it one cycle after the nGrants-th grant, scramble lengths, drain.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int nGrants,
                               input string what);
    int base;
    base = grantsSeen;
    @(posedge clock);
    #1 reqValid = mask;
    waitGrants(base + nGrants, what);
    #1 reqValid = '0;
    reqLen = '1;
    waitDrain(what);
  endtask

  task automatic checkAllZero(input string what);
    checkOutput({what, " req_grant"}, 32'(reqGrant), 32'd0);
    checkOutput({what, " spi_cs"}, 32'(spiCs), 32'd0);
    checkOutput({what, " txn_done"}, 32'(txnDone), 32'd0);
    checkOutput({what, " rx_valid"}, 32'(rxValid), 32'd0);
    checkOutput({what, " tx_pop"}, 32'(txPop), 32'd0);
    checkOutput({what, " eng_start"}, 32'(engStart), 32'd0);
    checkOutput({what, " eng_tx"}, 32'(engTx), 32'd0);
    checkOutput({what, " rx_data"}, 32'(rxData), 32'd0);
  endtask

  initial begin : stimulus
    int base;
    reset    = 1'b1;
    reqValid = '0;
    reqLen   = '0;
    spurDone = 1'b0;
    engKill  = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkAllZero("reset");

    $display("[TB] single byte on requester 0");
    setLen(0, 0);
    expectTxn(0, 0, 32'h0000_00A5, 32'h0000_003C);
    applyStimulus(4'b0001, 1, "t1");

    $display("[TB] four byte transaction on requester 2");
    setLen(2, 3);
    expectTxn(2, 3, 32'h4433_2211, 32'hC4C3_C2C1);
    applyStimulus(4'b0100, 1, "t3");

    $display("[TB] requester 3 drops req_valid after grant");
    setLen(3, 1);
    expectTxn(3, 1, 32'h0000_5B5A, 32'h0000_6B6A);
    applyStimulus(4'b1000, 1, "t6");

    $display("[TB] all requesters held, round robin");
    reqLen = '0;
    expectTxn(0, 0, 32'h01, 32'h81);
    expectTxn(1, 0, 32'h02, 32'h82);
    expectTxn(2, 0, 32'h03, 32'h83);
    expectTxn(3, 0, 32'h04, 32'h84);
    expectTxn(0, 0, 32'h05, 32'h85);
    applyStimulus(4'b1111, 5, "t2");

    $display("[TB] stray eng_done in IDLE and SETUP");
    setLen(1, 0);
    expectTxn(1, 0, 32'h77, 32'h88);
    base = grantsSeen;
    @(posedge clock);
    #1 spurDone = 1'b1;
    @(posedge clock);
    #1 spurDone = 1'b0;
    reqValid = 4'b0010;
    waitGrants(base + 1, "t5");
    #1 spurDone = 1'b1;
    reqValid = '0;
    @(posedge clock);
    #1 spurDone = 1'b0;
    waitDrain("t5");

    $display("[TB] reset during second byte");
    setLen(1, 3);
    expGrantQ.push_back(4'b0010);
    txQ.push_back(8'h51); txQ.push_back(8'h52); txQ.push_back(8'h53); txQ.push_back(8'h54);
    expEngQ.push_back(8'h51); expEngQ.push_back(8'h52);
    engRespQ.push_back(8'h61); engRespQ.push_back(8'h62);
    expRxQ.push_back(8'h61);
    base = startsSeen;
    @(posedge clock);
    #1 reqValid = 4'b0010;
    waitGrants(grantsSeen + 1, "t4");
    #1 reqValid = '0;
    waitStarts(base + 2, "t4");
    #1 engKill = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkAllZero("mid-txn reset");
    repeat (12) @(posedge clock);
    #1 engKill = 1'b0;
    txQ.delete();
    engRespQ.delete();

    $display("[TB] after reset requester 0 wins over 3");
    reqLen = '0;
    expectTxn(0, 0, 32'hA1, 32'hB1);
    expectTxn(3, 0, 32'hA2, 32'hB2);
    applyStimulus(4'b1001, 2, "t4 post-reset");

    checkOutput("leftover grants", expGrantQ.size(), 0);
    checkOutput("leftover eng_start", expEngQ.size(), 0);
    checkOutput("leftover rx_valid", expRxQ.size(), 0);
    checkOutput("leftover txn_done", expDoneQ.size(), 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
